// File: rtl/kypd_scan_controller.sv
// kypd_scan_controller
//   Scan sequencer for the Digilent KYPD 4x4 keypad. Drives one column low at
//   a time, samples the synchronized rows, rejects ghosted (multi-key) scans,
//   debounces the full-scan result and emits one press event per stable key.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   col_o[3:0]     column drive, active-low, at most one bit low
//   row_i[3:0]     raw asynchronous row inputs, active-low (pulled up)
//   key_valid_o    press event pending
//   key_code_o     hex code of the pending event
//   key_ready_i    consumer accepts the pending event
//   key_pressed_o  level: a debounced single key is currently held
//   evt_drop_o     one-cycle pulse: an unaccepted event was overwritten
module kypd_scan_controller #(
    parameter int ColumnSettleCycles = 1000,
    parameter int DebounceScans      = 4,
    parameter int SyncStages         = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [3:0] col_o,
    input  logic [3:0] row_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    input  logic       key_ready_i,
    output logic       key_pressed_o,
    output logic       evt_drop_o
);

    // Elaboration-time parameter checks
    if (ColumnSettleCycles < SyncStages + 2) begin : g_bad_settle
        $error("ColumnSettleCycles must be at least SyncStages+2");
    end
    if (DebounceScans < 1) begin : g_bad_debounce
        $error("DebounceScans must be at least 1");
    end
    if (SyncStages < 2) begin : g_bad_sync
        $error("SyncStages must be at least 2");
    end

    localparam int SW = (ColumnSettleCycles > 1) ? $clog2(ColumnSettleCycles) : 1;
    localparam int MW = $clog2(DebounceScans + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(ColumnSettleCycles - 1);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(DebounceScans);

    // Key codes indexed by latched-bit position {column, row}; entry i sits
    // at KEY_MAP[4*i +: 4]. Column 0 holds 1,4,7,0 for rows 0..3, and so on.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // column 3
        4'hE, 4'h9, 4'h6, 4'h3,   // column 2
        4'hF, 4'h8, 4'h5, 4'h2,   // column 1
        4'h0, 4'h7, 4'h4, 4'h1    // column 0
    };

    // Scan result encoding {none, code}; "none" always carries code 0 so
    // that equality compares are exact.
    localparam logic [4:0] CAND_NONE = 5'b1_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_EVAL
    } scan_state_t;

    // Complete scan position; a checker can bind to this single struct.
    typedef struct packed {
        scan_state_t state;
        logic [1:0]  col;
    } scan_pos_t;

    scan_pos_t     pos_q;
    logic [SW-1:0] settle_q;
    logic [15:0]   scan_bits_q;   // bit {col,row}, active-low as sampled
    logic [3:0]    sync_q [SyncStages];
    logic [3:0]    rows_s;

    // ------------------------------------------------------------------
    // Row synchronizers: plain flop chains, no input register. Reset to the
    // idle (pulled-up) level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= 4'hF;
            end
        end else begin
            sync_q[0] <= row_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rows_s = sync_q[SyncStages-1];

    // ------------------------------------------------------------------
    // Scan FSM. col_o is registered together with the next state so that
    // the column drive is aligned with the state it belongs to. ST_IDLE only
    // exists for the reset period; the first cycle after release is DRIVE(0).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q.state <= ST_IDLE;
            pos_q.col   <= 2'd0;
            settle_q    <= '0;
            col_o       <= 4'b1111;
            scan_bits_q <= 16'hFFFF;
        end else begin
            case (pos_q.state)
                ST_IDLE: begin
                    pos_q.state <= ST_DRIVE;
                    pos_q.col   <= 2'd0;
                    settle_q    <= '0;
                    col_o       <= 4'b1110;
                end
                ST_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        pos_q.state <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    scan_bits_q[{pos_q.col, 2'b00} +: 4] <= rows_s;
                    settle_q <= '0;
                    if (pos_q.col == 2'd3) begin
                        pos_q.state <= ST_EVAL;
                        col_o       <= 4'b1111;
                    end else begin
                        pos_q.state <= ST_DRIVE;
                        pos_q.col   <= pos_q.col + 2'd1;
                        col_o       <= ~(4'b0001 << (pos_q.col + 2'd1));
                    end
                end
                ST_EVAL: begin
                    pos_q.state <= ST_DRIVE;
                    pos_q.col   <= 2'd0;
                    settle_q    <= '0;
                    col_o       <= 4'b1110;
                end
                default: begin
                    pos_q.state <= ST_IDLE;
                    col_o       <= 4'b1111;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan evaluation: exactly one low bit gives a key, anything else is
    // "none" (covers both idle and ghosting patterns).
    // ------------------------------------------------------------------
    logic [4:0]    zero_cnt;
    logic [3:0]    hit_code;
    logic [4:0]    cand;
    logic [4:0]    prev_q;
    logic [4:0]    stable_q;
    logic [MW-1:0] match_q;
    logic [MW-1:0] match_nxt;
    logic          take;
    logic          emit;
    logic          in_eval;

    always_comb begin
        zero_cnt = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (!scan_bits_q[i]) begin
                zero_cnt = zero_cnt + 5'd1;
                hit_code = KEY_MAP[i*4 +: 4];
            end
        end
        cand = (zero_cnt == 5'd1) ? {1'b0, hit_code} : CAND_NONE;
    end

    always_comb begin
        in_eval = (pos_q.state == ST_EVAL);
        if (cand == prev_q) begin
            match_nxt = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
        end else begin
            match_nxt = MW'(1);
        end
        take = (match_nxt == MATCH_MAX) && (cand != stable_q);
        // Only transitions into a key produce an event; key -> none is silent.
        emit = take && !cand[4];
    end

    // ------------------------------------------------------------------
    // Debounce and event output.
    // Handshake: an event transfers on a clock edge where key_valid_o and
    // key_ready_i are both 1; key_ready_i is ignored while key_valid_o is 0.
    // A new event always wins the valid register: if the old one is being
    // accepted on the same edge it is simply replaced, otherwise it is lost
    // and evt_drop_o pulses for one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q        <= CAND_NONE;
            stable_q      <= CAND_NONE;
            match_q       <= '0;
            key_valid_o   <= 1'b0;
            key_code_o    <= 4'h0;
            key_pressed_o <= 1'b0;
            evt_drop_o    <= 1'b0;
        end else begin
            evt_drop_o <= 1'b0;
            if (in_eval) begin
                prev_q  <= cand;
                match_q <= match_nxt;
                if (take) begin
                    stable_q      <= cand;
                    key_pressed_o <= !cand[4];
                end
            end
            if (in_eval && emit) begin
                key_valid_o <= 1'b1;
                key_code_o  <= cand[3:0];
                evt_drop_o  <= key_valid_o && !key_ready_i;
            end else if (key_valid_o && key_ready_i) begin
                key_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kypd_scan_controller.sv
// tb_kypd_scan_controller
//   Self-checking bench for kypd_scan_controller with ColumnSettleCycles=8,
//   DebounceScans=3, SyncStages=2 (scan period 37 cycles). A small keypad
//   model turns the held-key set into row levels from the driven columns.
//   Expected press events are queued with their expected cycle and drop flag
//   and compared when the DUT presents a new event.
module tb_kypd_scan_controller;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int SYNC   = 2;
    localparam int PERIOD = 4 * (SETTLE + 1) + 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_o;
    logic [3:0] row_i;
    logic       key_valid_o;
    logic [3:0] key_code_o;
    logic       key_ready_i = 1'b1;
    logic       key_pressed_o;
    logic       evt_drop_o;

    always #5 clk = ~clk;

    // cycle index since reset release: cycle n starts at the n-th posedge
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    kypd_scan_controller #(
        .ColumnSettleCycles(SETTLE),
        .DebounceScans     (DEB),
        .SyncStages        (SYNC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .col_o        (col_o),
        .row_i        (row_i),
        .key_valid_o  (key_valid_o),
        .key_code_o   (key_code_o),
        .key_ready_i  (key_ready_i),
        .key_pressed_o(key_pressed_o),
        .evt_drop_o   (evt_drop_o)
    );

    // ---------------- keypad model ----------------
    // held bit r*4+c: key at row r, column c is pressed
    logic [15:0] held = 16'h0000;

    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_o[c] && held[r*4+c]) row_i[r] = 1'b0;
            end
        end
    end

    // keypad layout, row-major
    function automatic int key_idx(input logic [3:0] k);
        case (k)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'h0: return 12; 4'hF: return 13; 4'hE: return 14; default: return 15;
        endcase
    endfunction

    task automatic press(input logic [3:0] k);
        held[key_idx(k)] = 1'b1;
    endtask

    function automatic logic [3:0] exp_col(input int c);
        int p;
        if (c == 0) return 4'hF;
        p = (c - 1) % PERIOD;
        if (p == PERIOD - 1) return 4'hF;
        return ~(4'b0001 << (p / (SETTLE + 1)));
    endfunction

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    // entry: {expected cycle[15:0], drop flag, code[3:0]}
    logic [20:0] exp_q[$];
    int          drop_cnt = 0;
    logic        v_prev = 1'b0;
    logic        r_prev = 1'b0;
    logic [3:0]  c_prev = 4'h0;

    task automatic expect_evt(input int at, input logic drop, input logic [3:0] code);
        exp_q.push_back({16'(at), drop, code});
    endtask

    always @(negedge clk) begin
        logic [20:0] e;
        #1;
        if (rst) begin
            v_prev = 1'b0;
            r_prev = 1'b0;
            c_prev = 4'h0;
        end else begin
            check("col_o", {28'h0, col_o}, {28'h0, exp_col(cyc)});
            if (evt_drop_o) drop_cnt++;
            // a new event: valid rises, follows a transfer, or changes code
            if (key_valid_o && (!v_prev || r_prev || key_code_o != c_prev)) begin
                if (exp_q.size() == 0) begin
                    check("spurious_evt", {26'h0, key_valid_o, evt_drop_o, key_code_o}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_code", {28'h0, key_code_o}, {28'h0, e[3:0]});
                    check("evt_cycle", cyc, {16'h0, e[20:5]});
                    check("evt_drop", {31'h0, evt_drop_o}, {31'h0, e[4]});
                end
            end
            v_prev = key_valid_o;
            r_prev = key_ready_i;
            c_prev = key_code_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_col"},     {28'h0, col_o},        32'hF);
        check({tag, "_valid"},   {31'h0, key_valid_o},  32'h0);
        check({tag, "_code"},    {28'h0, key_code_o},   32'h0);
        check({tag, "_pressed"}, {31'h0, key_pressed_o}, 32'h0);
        check({tag, "_drop"},    {31'h0, evt_drop_o},   32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1: idle scan, no keys
        held        = 16'h0;
        key_ready_i = 1'b1;
        do_reset();
        for (int i = 1; i <= 2 * PERIOD; i++) begin
            wait_cyc(i);
            check("t1_valid", {31'h0, key_valid_o}, 32'h0);
            check("t1_pressed", {31'h0, key_pressed_o}, 32'h0);
        end

        // 2: hold '5', one event after the 3rd EVAL, none over 10 more scans
        held = 16'h0;
        press(4'h5);
        expect_evt(3 * PERIOD + 1, 1'b0, 4'h5);
        do_reset();
        wait_cyc(3 * PERIOD);
        check("t2_pressed_before", {31'h0, key_pressed_o}, 32'h0);
        wait_cyc(3 * PERIOD + 1);
        check("t2_pressed", {31'h0, key_pressed_o}, 32'h1);
        check("t2_valid", {31'h0, key_valid_o}, 32'h1);
        wait_cyc(3 * PERIOD + 2);
        check("t2_valid_drop", {31'h0, key_valid_o}, 32'h0);
        wait_cyc(13 * PERIOD);
        check("t2_still_pressed", {31'h0, key_pressed_o}, 32'h1);
        held = 16'h0;
        wait_cyc(16 * PERIOD);
        check("t2_release_hold", {31'h0, key_pressed_o}, 32'h1);
        wait_cyc(16 * PERIOD + 1);
        check("t2_released", {31'h0, key_pressed_o}, 32'h0);
        check("t2_no_evt", {31'h0, key_valid_o}, 32'h0);

        // 3: '9' in scans 1,3,4,5, absent in scan 2
        held = 16'h0;
        press(4'h9);
        expect_evt(5 * PERIOD + 1, 1'b0, 4'h9);
        do_reset();
        wait_cyc(PERIOD);
        held = 16'h0;
        wait_cyc(2 * PERIOD);
        press(4'h9);
        wait_cyc(4 * PERIOD + 1);
        check("t3_no_evt_s4", {31'h0, key_valid_o}, 32'h0);
        wait_cyc(5 * PERIOD);
        check("t3_no_press_s4", {31'h0, key_pressed_o}, 32'h0);
        wait_cyc(5 * PERIOD + 1);
        check("t3_pressed", {31'h0, key_pressed_o}, 32'h1);
        held = 16'h0;

        // 4: '1' and '6' together -> ghosting, no event
        do_reset();
        press(4'h1);
        press(4'h6);
        wait_cyc(6 * PERIOD + 1);
        check("t4_valid", {31'h0, key_valid_o}, 32'h0);
        check("t4_pressed", {31'h0, key_pressed_o}, 32'h0);
        wait_cyc(6 * PERIOD + 2);
        check("t4_valid_late", {31'h0, key_valid_o}, 32'h0);
        held = 16'h0;

        // 5: consumer stalled: '7', release, 'D' overwrites with a drop
        key_ready_i = 1'b0;
        press(4'h7);
        expect_evt(3 * PERIOD + 1, 1'b0, 4'h7);
        expect_evt(9 * PERIOD + 1, 1'b1, 4'hD);
        do_reset();
        wait_cyc(3 * PERIOD);
        held = 16'h0;
        wait_cyc(6 * PERIOD + 1);
        check("t5_released", {31'h0, key_pressed_o}, 32'h0);
        check("t5_valid_held", {31'h0, key_valid_o}, 32'h1);
        check("t5_code_held", {28'h0, key_code_o}, 32'h7);
        wait_cyc(6 * PERIOD + 2);
        press(4'hD);
        wait_cyc(9 * PERIOD + 2);
        check("t5_drop_once", {31'h0, evt_drop_o}, 32'h0);
        check("t5_code_d", {28'h0, key_code_o}, 32'hD);
        wait_cyc(9 * PERIOD + 7);
        check("t5_drop_cnt", drop_cnt, 1);
        key_ready_i = 1'b1;
        wait_cyc(9 * PERIOD + 8);
        key_ready_i = 1'b0;
        check("t5_valid_after_accept", {31'h0, key_valid_o}, 32'h0);
        held = 16'h0;
        key_ready_i = 1'b1;

        // 6: hold 'A', async reset mid-DRIVE(2), event re-emitted
        press(4'hA);
        expect_evt(3 * PERIOD + 1, 1'b0, 4'hA);
        do_reset();
        wait_cyc(3 * PERIOD + 1);
        check("t6_pressed", {31'h0, key_pressed_o}, 32'h1);
        wait_cyc(3 * PERIOD + 2 * (SETTLE + 1) + 4);
        check("t6_col_before", {28'h0, col_o}, 32'hB);
        #2 rst = 1'b1;
        #1 check_idle_outputs("t6_async");
        repeat (2) @(negedge clk);
        expect_evt(3 * PERIOD + 1, 1'b0, 4'hA);
        rst = 1'b0;
        wait_cyc(1);
        check("t6_restart_col", {28'h0, col_o}, 32'hE);
        wait_cyc(3 * PERIOD);
        check("t6_not_yet", {31'h0, key_pressed_o}, 32'h0);
        wait_cyc(3 * PERIOD + 1);
        check("t6_repressed", {31'h0, key_pressed_o}, 32'h1);
        wait_cyc(3 * PERIOD + 3);
        held = 16'h0;

        // ---------------- report ----------------
        check("exp_q_drained", exp_q.size(), 0);
        check("drop_total", drop_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kypd_scan_controller.md
Name: kypd_scan_controller

Overview:
Scan sequencer for the Digilent KYPD 4x4 keypad. It drives the column lines one at a time, samples the asynchronous row lines through internal single-bit synchronizers, and debounces the 16-key scan result. It rejects multi-key presses and emits one press event per stable key through a valid/ready handshake. It sits between the Pmod pins and the keypad decode/consumer logic, and it is the only user of the row synchronizers.

Parameters:
ColumnSettleCycles, 1000, cycles a column is held driven before its rows are sampled; must be >= SyncStages+2 (elaboration-time check).
DebounceScans, 4, consecutive identical full-scan results required before the stable key state changes; must be >= 1.
SyncStages, 2, depth of each row synchronizer chain; must be >= 2.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
col_o  out  4  column drive, active-low; at most one bit low at any time
row_i  in  4  raw row inputs from the Pmod, asynchronous, active-low (pulled up)
key_valid_o  out  1  press event pending
key_code_o  out  4  hex code of the pending event; stable while key_valid_o=1 unless overwritten
key_ready_i  in  1  consumer accepts the event
key_pressed_o  out  1  level: a debounced single key is currently held
evt_drop_o  out  1  one-cycle pulse: an unaccepted event was overwritten

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: col_o=4'b1111, key_valid_o=0, key_code_o=4'h0, key_pressed_o=0, evt_drop_o=0. All counters, synchronizers and debounce state are cleared, and stable state is "none".
- Row synchronization: each row_i bit passes through a SyncStages-deep chain with no input register. Only the synchronized rows are used.
- FSM states: DRIVE(c), SAMPLE(c), EVAL.
  - First cycle after reset release: DRIVE(0).
  - DRIVE(c): col_o has bit c low and all others high. Held for exactly ColumnSettleCycles cycles, then SAMPLE(c).
  - SAMPLE(c): col_o unchanged for 1 cycle. Latch the 4 synchronized rows for column c, then go to DRIVE(c+1). For c=3, go to EVAL.
  - EVAL: col_o=4'b1111 for 1 cycle, then DRIVE(0).
  - Scan period = 4*(ColumnSettleCycles+1)+1 cycles.
- Scan result in EVAL:
  - Exactly one of the 16 latched bits low gives candidate = that key's code.
  - Zero or two or more bits low gives candidate = none (ghosting rejection).
- Code map, row r = row_i bit, column c = col_o bit:
  - r0: c0..3 = 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Debounce:
  - Match counter increments when the candidate equals the previous scan's candidate, saturating at DebounceScans. Otherwise it reloads to 1.
  - When the counter reaches DebounceScans and candidate != stable, stable := candidate. This update happens in EVAL.
- Stable-state transitions:
  - none -> k: key_pressed_o=1, emit event k.
  - k -> j (j != k, direct): key_pressed_o stays 1, emit event j.
  - k -> none: key_pressed_o=0, no event.
  - A held key emits exactly one event.
- Event timing: key_valid_o and key_code_o update in the cycle after the deciding EVAL.
- Handshake:
  - Transfer occurs on a clock edge with key_valid_o=1 and key_ready_i=1. key_valid_o drops the next cycle unless a new event is emitted in the same cycle.
  - A new event while key_valid_o=1 and not accepted overwrites key_code_o, keeps valid high, and pulses evt_drop_o for 1 cycle.
  - If the new event coincides with acceptance of the old one, the old event is transferred, the new one becomes pending, and there is no drop.
- key_ready_i is ignored while key_valid_o=0.
- Mid-operation reset: all outputs return to reset values immediately (asynchronous), and the scan restarts at DRIVE(0).

Test Plan:
Bench parameters are ColumnSettleCycles=8, DebounceScans=3, SyncStages=2, giving a scan period of 37 cycles.
1. Reset, then release with row_i=4'hF -> col_o sequence: 1110 x9, 1101 x9, 1011 x9, 0111 x9, 1111 x1, then repeat. key_valid_o=0 and key_pressed_o=0 throughout.
2. Hold key '5' (row_i[1] low whenever col_o[1]=0) from before scan 1, key_ready_i=1 -> key_valid_o=1 with key_code_o=4'h5 for 1 cycle after the 3rd EVAL. key_pressed_o=1 from then. No second event over 10 scans. After release, key_pressed_o=0 after 3 further scans.
3. Key '9' present in scans 1, 3, 4, 5 and absent in scan 2 -> no event through scan 4. Event with code 4'h9 after scan 5's EVAL.
4. Keys '1' and '6' held simultaneously for 6 scans -> no event, key_pressed_o=0.
5. key_ready_i=0: stable '7', release, then stable 'D' -> key_valid_o stays 1, key_code_o goes 7 -> D, evt_drop_o pulses exactly once. Then key_ready_i=1 for 1 cycle -> key_valid_o=0 the next cycle.
6. Hold 'A' until key_pressed_o=1, then assert rst_i mid-DRIVE(2) -> col_o=4'b1111 and all outputs 0 in the same cycle. After release, scan restarts at col_o=1110, and an event with code 4'hA is re-emitted after 3 scans.
